// File: rtl/data_mem_arbiter_pkg.sv
// Shared types, constants and the byte-merge helper for the data_mem arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_t;

    localparam int N_REQ      = 2;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    // Enabled bytes come from new_word, the rest keep old_word.
    function automatic logic [MEM_DATA_W-1:0] be_merge(
        input logic [MEM_DATA_W-1:0] old_word,
        input logic [MEM_DATA_W-1:0] new_word,
        input logic [MEM_BE_W-1:0]   be
    );
        logic [MEM_DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MEM_BE_W; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and data_mem bus bundle for data_mem_arbiter.
interface data_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = MEM_DATA_W
);
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0]                 req_ready;
    logic [N_REQ-1:0]                 req_we;
    logic [N_REQ-1:0][ADDR_W-1:0]     req_addr;
    logic [N_REQ-1:0][DATA_W-1:0]     req_wdata;
    logic [N_REQ-1:0][DATA_W/8-1:0]   req_be;
    logic [N_REQ-1:0]                 rsp_valid;
    logic [DATA_W-1:0]                rsp_rdata;
    logic                             mem_wrt_en;
    logic [ADDR_W-1:0]                mem_address;
    logic [DATA_W-1:0]                mem_write_data;
    logic [DATA_W-1:0]                mem_read_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, mem_wrt_en, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, mem_wrt_en, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Two-requester grant selection. MEM_ARB_RR_EN selects round-robin on ties,
// otherwise port 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
`endif
    input  logic [N_REQ-1:0] valid,
    output logic [N_REQ-1:0] grant
);

`ifdef MEM_ARB_RR_EN
    // Index of the port granted most recently; resets to 1 so port 0 wins first.
    logic last_q;
    logic last_d;

    always_comb begin
        grant  = valid;
        last_d = last_q;
        if (valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
        if (accept) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data_mem between two requesters; sub-word stores use read-modify-write.
// Optional MEM_ARB_RR_EN enables round-robin tie breaking.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = MEM_DATA_W
)(
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);

    arb_state_t               state_q, state_d;
    logic [N_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic                     rmw_port_q, rmw_port_d;

    logic [N_REQ-1:0]         grant;
    logic                     accept;
    logic                     sel;

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
`endif
        .valid  (bus.req_valid),
        .grant  (grant)
    );

    assign sel = grant[1];

    always_comb begin
        state_d            = state_q;
        rsp_valid_d        = '0;
        rsp_rdata_d        = rsp_rdata_q;
        wr_addr_d          = wr_addr_q;
        wr_data_d          = wr_data_q;
        rmw_port_d         = rmw_port_q;
        accept             = 1'b0;
        bus.req_ready      = '0;
        bus.mem_wrt_en     = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;

        case (state_q)
            IDLE: begin
                if (!rst && grant != '0) begin
                    bus.req_ready   = grant;
                    accept          = 1'b1;
                    bus.mem_address = bus.req_addr[sel];
                    if (!bus.req_we[sel]) begin
                        rsp_rdata_d      = bus.mem_read_data;
                        rsp_valid_d[sel] = 1'b1;
                    end else if (&bus.req_be[sel]) begin
                        bus.mem_wrt_en     = 1'b1;
                        bus.mem_write_data = bus.req_wdata[sel];
                        rsp_rdata_d        = '0;
                        rsp_valid_d[sel]   = 1'b1;
                    end else if (~|bus.req_be[sel]) begin
                        rsp_rdata_d      = '0;
                        rsp_valid_d[sel] = 1'b1;
                    end else begin
                        // Old word is on mem_read_data now; merge and write it next cycle.
                        wr_addr_d  = bus.req_addr[sel];
                        wr_data_d  = be_merge(bus.mem_read_data, bus.req_wdata[sel], bus.req_be[sel]);
                        rmw_port_d = sel;
                        state_d    = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                bus.mem_wrt_en          = 1'b1;
                bus.mem_address         = wr_addr_q;
                bus.mem_write_data      = wr_data_q;
                rsp_rdata_d             = '0;
                rsp_valid_d[rmw_port_q] = 1'b1;
                state_d                 = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rmw_port_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rmw_port_q  <= rmw_port_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small data_mem model.
module tb_data_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    data_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // data_mem model: combinational read, synchronous full-word write, 8 words.
    logic [63:0] mem [8];
    logic        pre_we;
    logic [2:0]  pre_idx;
    logic [63:0] pre_data;

    assign bus.mem_read_data = mem[bus.mem_address[5:3]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (bus.mem_wrt_en) begin
            mem[bus.mem_address[5:3]] <= bus.mem_write_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be);
        bus.req_valid[port] = 1'b1;
        bus.req_we[port]    = we;
        bus.req_addr[port]  = addr;
        bus.req_wdata[port] = wdata;
        bus.req_be[port]    = be;
    endtask

    task automatic clear();
        bus.req_valid = '0;
    endtask

    logic [1:0] tie_exp [4];

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        pre_we    = 1'b0;
        pre_idx   = '0;
        pre_data  = '0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
`ifdef MEM_ARB_RR_EN
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif

        // Preload memory while held in reset, with requests pending.
        #1;
        pre_we = 1'b1; pre_idx = 3'd0; pre_data = 64'hFFAAFFAAFFAAFFAA;
        step();
        pre_idx = 3'd1; pre_data = 64'h778899AABBCCDDEE;
        step();
        pre_idx = 3'd2; pre_data = 64'h0;
        step();
        pre_we = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rdata", bus.rsp_rdata, 64'h0);
        chk("rst_wrt_en", 64'(bus.mem_wrt_en), 64'h0);
        chk("rst_addr", bus.mem_address, 64'h0);
        step();
        clear();
        rst = 1'b0;

        // Load port 0, addr 0.
        drive(0, 1'b0, 64'd0, 64'h0, 8'h00);
        @(negedge clk);
        chk("ld_ready", 64'(bus.req_ready), 64'h1);
        chk("ld_wrt_en", 64'(bus.mem_wrt_en), 64'h0);
        step();
        clear();
        @(negedge clk);
        chk("ld_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("ld_rdata", bus.rsp_rdata, 64'hFFAAFFAAFFAAFFAA);

        // Full store port 1, addr 16.
        step();
        drive(1, 1'b1, 64'd16, 64'h1122334455667788, 8'hFF);
        @(negedge clk);
        chk("fst_ready", 64'(bus.req_ready), 64'h2);
        chk("fst_wrt_en", 64'(bus.mem_wrt_en), 64'h1);
        chk("fst_addr", bus.mem_address, 64'd16);
        chk("fst_wdata", bus.mem_write_data, 64'h1122334455667788);
        step();
        clear();
        @(negedge clk);
        chk("fst_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("fst_rdata_zero", bus.rsp_rdata, 64'h0);
        chk("fst_wrt_en_off", 64'(bus.mem_wrt_en), 64'h0);
        step();
        drive(0, 1'b0, 64'd16, 64'h0, 8'h00);
        step();
        clear();
        @(negedge clk);
        chk("fst_readback", bus.rsp_rdata, 64'h1122334455667788);

        // Partial store port 0, addr 8, low four bytes cleared.
        step();
        drive(0, 1'b1, 64'd8, 64'h0, 8'h0F);
        @(negedge clk);
        chk("pst_ready", 64'(bus.req_ready), 64'h1);
        chk("pst_rd_wrt_en", 64'(bus.mem_wrt_en), 64'h0);
        chk("pst_rd_addr", bus.mem_address, 64'd8);
        step();
        clear();
        drive(1, 1'b0, 64'd0, 64'h0, 8'h00);
        @(negedge clk);
        chk("pst_wr_ready", 64'(bus.req_ready), 64'h0);
        chk("pst_wr_en", 64'(bus.mem_wrt_en), 64'h1);
        chk("pst_wr_addr", bus.mem_address, 64'd8);
        chk("pst_wr_data", bus.mem_write_data, 64'h778899AA00000000);
        chk("pst_wr_rsp", 64'(bus.rsp_valid), 64'h0);
        step();
        @(negedge clk);
        chk("pst_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("pst_rdata_zero", bus.rsp_rdata, 64'h0);
        chk("pst_overlap_ready", 64'(bus.req_ready), 64'h2);
        chk("pst_mem", mem[1], 64'h778899AA00000000);
        step();
        clear();
        @(negedge clk);
        chk("ovl_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("ovl_rdata", bus.rsp_rdata, 64'hFFAAFFAAFFAAFFAA);

        // Tie: both ports hold loads for four cycles.
        step();
        drive(0, 1'b0, 64'd0, 64'h0, 8'h00);
        drive(1, 1'b0, 64'd16, 64'h0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tie_grant%0d", i), 64'(bus.req_ready), 64'(tie_exp[i]));
            @(posedge clk);
        end
        #1;
        clear();

        // Reset asserted while the RMW write is pending.
        drive(1, 1'b1, 64'd0, 64'hFFFFFFFFFFFFFFFF, 8'h01);
        @(negedge clk);
        chk("rrst_accept", 64'(bus.req_ready), 64'h2);
        step();
        clear();
        rst = 1'b1;
        @(negedge clk);
        chk("rrst_wrt_en", 64'(bus.mem_wrt_en), 64'h0);
        chk("rrst_ready", 64'(bus.req_ready), 64'h0);
        chk("rrst_rsp", 64'(bus.rsp_valid), 64'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rrst_rsp_after", 64'(bus.rsp_valid), 64'h0);
        chk("rrst_mem", mem[0], 64'hFFAAFFAAFFAAFFAA);
        step();
        drive(1, 1'b0, 64'd0, 64'h0, 8'h00);
        @(negedge clk);
        chk("rrst_regrant", 64'(bus.req_ready), 64'h2);
        step();
        clear();
        @(negedge clk);
        chk("rrst_ld_rsp", 64'(bus.rsp_valid), 64'h2);
        chk("rrst_ld_rdata", bus.rsp_rdata, 64'hFFAAFFAAFFAAFFAA);

        // Store with be = 0: accepted, nothing written.
        step();
        drive(0, 1'b1, 64'd0, 64'h0, 8'h00);
        @(negedge clk);
        chk("be0_ready", 64'(bus.req_ready), 64'h1);
        chk("be0_wrt_en", 64'(bus.mem_wrt_en), 64'h0);
        step();
        clear();
        @(negedge clk);
        chk("be0_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("be0_rdata_zero", bus.rsp_rdata, 64'h0);
        chk("be0_mem", mem[0], 64'hFFAAFFAAFFAAFFAA);
        step();
        @(negedge clk);
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("idle_addr", bus.mem_address, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
